uart_tx_arbiter: RTL and testbench

Shares the single byte-level UART transmitter among `NUM_REQ` on-chip message sources (command sender, OK responder, LED/mode reporter). It grants the channel to one requester at a time for a whole multi-byte frame and streams that frame's bytes into the transmitter's start/busy handshake. Grants are round-robin with a mandatory inter-frame gap, and a stall watchdog aborts frames whose owner stops supplying bytes. It sits between the message generators and `uart_tx` inside the UART server top level.

---
 rtl/uart_arb_pkg.sv | 17 +
 rtl/uart_tx_arbiter_rr_pick.sv | 34 +++
 rtl/uart_tx_arbiter.sv | 159 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_arb_pkg;

  localparam int BYTE_W           = 8;
  localparam int DEFAULT_IDLE_GAP = 16;
  localparam int DEFAULT_TIMEOUT  = 50000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SEND,
    ST_HOLD,
    ST_DRAIN,
    ST_GAP
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: the search starts one past the last
// served index and wraps, so the most recently served requester ranks lowest.
module rr_pick #(
  parameter int N  = 3,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  always_comb begin
    int c;
    logic [IW-1:0] cand;
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    c       = 0;
    cand    = '0;
    for (int k = 1; k <= N; k++) begin
      c = int'(last_i) + k;
      if (c >= N) c = c - N;
      cand = IW'(c);
      if (!any_o && req_i[cand]) begin
        any_o         = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Frame-level arbiter in front of a byte UART transmitter: round-robin grant,
// per-byte start/busy handshake, inter-frame gap and a stall watchdog.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ  = 3,
  parameter int IDLE_GAP = DEFAULT_IDLE_GAP,
  parameter int TIMEOUT  = DEFAULT_TIMEOUT
) (
  input  logic                      iCLK,
  input  logic                      RST,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [BYTE_W*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      tx_start,
  output logic [BYTE_W-1:0]         tx_data,
  input  logic                      tx_busy,
  output logic                      frame_done,
  output logic                      frame_abort
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int WW = $clog2(TIMEOUT);
  localparam int GW = $clog2(IDLE_GAP + 1);
  localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(IDLE_GAP);

  arb_state_e          state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [IW-1:0]       owner_q, owner_d;
  logic [IW-1:0]       last_served_q, last_served_d;
  logic [BYTE_W-1:0]   data_q, data_d;
  logic                last_q, last_d;
  logic [WW-1:0]       wdog_q, wdog_d;
  logic [GW-1:0]       gap_q, gap_d;
  logic                start_q, start_d;
  logic                done_q, done_d;
  logic                abort_q, abort_d;

  logic [NUM_REQ-1:0]  pick_grant;
  logic [IW-1:0]       pick_idx;
  logic                pick_any;
  logic [BYTE_W-1:0]   lane_data [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
    assign lane_data[gi] = req_data[gi*BYTE_W +: BYTE_W];
  end

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req_i   (req_valid),
    .last_i  (last_served_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  always_ff @(posedge iCLK or posedge RST) begin
    if (RST) begin
      state_q       <= ST_IDLE;
      grant_q       <= '0;
      owner_q       <= '0;
      last_served_q <= IW'(NUM_REQ - 1);
      data_q        <= '0;
      last_q        <= 1'b0;
      wdog_q        <= '0;
      gap_q         <= '0;
      start_q       <= 1'b0;
      done_q        <= 1'b0;
      abort_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      owner_q       <= owner_d;
      last_served_q <= last_served_d;
      data_q        <= data_d;
      last_q        <= last_d;
      wdog_q        <= wdog_d;
      gap_q         <= gap_d;
      start_q       <= start_d;
      done_q        <= done_d;
      abort_q       <= abort_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    owner_d       = owner_q;
    last_served_d = last_served_q;
    data_d        = data_q;
    last_d        = last_q;
    wdog_d        = wdog_q;
    gap_d         = gap_q;
    start_d       = 1'b0;
    done_d        = 1'b0;
    abort_d       = 1'b0;
    req_ready     = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d = pick_grant;
          owner_d = pick_idx;
          wdog_d  = '0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (req_valid[owner_q]) begin
          req_ready = grant_q;
          data_d    = lane_data[owner_q];
          last_d    = req_last[owner_q];
          wdog_d    = '0;
          start_d   = 1'b1;
          state_d   = ST_SEND;
        end else if (wdog_q == WD_LAST) begin
          abort_d       = 1'b1;
          wdog_d        = '0;
          grant_d       = '0;
          last_served_d = owner_q;
          gap_d         = '0;
          state_d       = ST_GAP;
        end else begin
          wdog_d = wdog_q + WW'(1);
        end
      end
      ST_SEND:  state_d = ST_HOLD;
      // tx_busy only rises the cycle after tx_start, so HOLD skips that cycle.
      ST_HOLD:  state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (!tx_busy) begin
          if (last_q) begin
            done_d        = 1'b1;
            grant_d       = '0;
            last_served_d = owner_q;
            gap_d         = '0;
            state_d       = ST_GAP;
          end else begin
            state_d = ST_FETCH;
          end
        end
      end
      ST_GAP: begin
        // First GAP cycle carries the done/abort pulse; IDLE_GAP idle cycles follow.
        if (gap_q == GAP_LAST) state_d = ST_IDLE;
        else                   gap_d   = gap_q + GW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign grant       = grant_q;
  assign tx_start    = start_q;
  assign tx_data     = data_q;
  assign frame_done  = done_q;
  assign frame_abort = abort_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: lane queues feed the requesters, a
// stub transmitter answers tx_start, expected bytes are checked at tx_start.
module tb_uart_tx_arbiter;
  import uart_arb_pkg::*;

  localparam int NUM_REQ  = 3;
  localparam int IDLE_GAP = 16;
  localparam int TIMEOUT  = 40;
  localparam int BUSY_CYC = 10;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_REQ-1:0]        req_valid;
  logic [BYTE_W*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        grant;
  logic                      tx_start;
  logic [BYTE_W-1:0]         tx_data;
  logic                      tx_busy;
  logic                      frame_done;
  logic                      frame_abort;

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .IDLE_GAP(IDLE_GAP), .TIMEOUT(TIMEOUT)) dut (
    .iCLK        (clk),
    .RST         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .grant       (grant),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .frame_done  (frame_done),
    .frame_abort (frame_abort)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] idx;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q [$];
  logic [8:0] lane_q [NUM_REQ][$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cnt = 0, done_cnt = 0, abort_cnt = 0;
  int last_start_cyc = 0, last_done_cyc = 0, last_abort_cyc = 0;
  int busy_left = 0;
  logic [NUM_REQ-1:0] acc;
  logic               start_seen;
  logic [7:0]         prev_tx_data;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic drive_lanes();
    logic [8:0] h;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (lane_q[i].size() > 0) begin
        h = lane_q[i][0];
        req_valid[i]        = 1'b1;
        req_data[i*8 +: 8]  = h[7:0];
        req_last[i]         = h[8];
      end else begin
        req_valid[i]        = 1'b0;
        req_data[i*8 +: 8]  = 8'h00;
        req_last[i]         = 1'b0;
      end
    end
  endtask

  task automatic lane_push(input int lane, input logic [7:0] b, input logic last);
    lane_q[lane].push_back({last, b});
  endtask

  task automatic exp_push(input int lane, input logic [7:0] b);
    exp_t e;
    e.idx  = 2'(lane);
    e.data = b;
    exp_q.push_back(e);
  endtask

  task automatic monitor();
    exp_t e;
    acc        = req_ready;
    start_seen = tx_start;
    if (rst) begin
      prev_tx_data = 8'h00;
    end else begin
      if (req_ready != '0) begin
        chk("ready_owner", req_ready & ~grant, 0);
        chk("ready_onehot", $onehot(req_ready), 1);
      end
      if (tx_start) begin
        start_cnt++;
        last_start_cyc = cyc;
        if (exp_q.size() == 0) chk("unexpected_start", 1, 0);
        else begin
          e = exp_q.pop_front();
          $display("tx byte %02h owner grant %b at cycle %0d", tx_data, grant, cyc);
          chk("tx_data", tx_data, e.data);
          chk("tx_grant", grant, NUM_REQ'(1) << e.idx);
        end
      end else begin
        chk("tx_data_hold", tx_data, prev_tx_data);
      end
      prev_tx_data = tx_data;
      if (frame_done)  begin done_cnt++;  last_done_cyc  = cyc; end
      if (frame_abort) begin abort_cnt++; last_abort_cyc = cyc; end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (acc[i]) begin
        if (lane_q[i].size() == 0) chk("ready_empty", 1, 0);
        else void'(lane_q[i].pop_front());
      end
    end
    if (start_seen) busy_left = BUSY_CYC;
    if (busy_left > 0) begin
      tx_busy = 1'b1;
      busy_left--;
    end else begin
      tx_busy = 1'b0;
    end
    drive_lanes();
  endtask

  function automatic int count_of(input int kind);
    case (kind)
      0:       return done_cnt;
      1:       return abort_cnt;
      default: return start_cnt;
    endcase
  endfunction

  task automatic wait_for(input string tag, input int kind, input int target, input int limit);
    int n = 0;
    while (count_of(kind) < target && n < limit) begin
      tick();
      n++;
    end
    chk(tag, count_of(kind) >= target, 1);
  endtask

  task automatic flush();
    for (int i = 0; i < NUM_REQ; i++) lane_q[i].delete();
    exp_q.delete();
    busy_left = 0;
    tx_busy   = 1'b0;
    drive_lanes();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    flush();
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic settle();
    repeat (IDLE_GAP + 4) tick();
  endtask

  initial begin
    int t0, bad, base_d, base_a, base_s, s41, dc1;
    rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0; tx_busy = 1'b0;
    prev_tx_data = 8'h00; acc = '0; start_seen = 1'b0;
    repeat (3) tick();
    chk("rst_outputs", {grant, req_ready, tx_start, tx_data, frame_done, frame_abort}, 0);
    rst = 1'b0;
    tick();

    // Single two-byte frame from requester 0
    t0 = cyc;
    lane_push(0, 8'h4F, 1'b0); lane_push(0, 8'h4B, 1'b1);
    exp_push(0, 8'h4F); exp_push(0, 8'h4B);
    drive_lanes();
    wait_for("single_done", 0, 1, 200);
    chk("single_latency", last_start_cyc - t0 >= 2, 1);
    chk("single_starts", start_cnt, 2);
    chk("single_done_cnt", done_cnt, 1);
    bad = 0;
    repeat (IDLE_GAP) begin
      if (grant != '0) bad++;
      tick();
    end
    chk("gap_grant_zero", bad, 0);
    chk("single_sb", exp_q.size(), 0);
    settle();

    // Contention from reset: two rounds, each 0,1,2
    for (int round = 0; round < 2; round++) begin
      if (round == 0) do_reset();
      t0 = cyc;
      base_s = start_cnt;
      base_d = done_cnt;
      for (int i = 0; i < NUM_REQ; i++) begin
        lane_push(i, 8'hA0 + 8'(round * 16 + i), 1'b1);
        exp_push(i, 8'hA0 + 8'(round * 16 + i));
      end
      drive_lanes();
      wait_for("contend_done", 0, base_d + 3, 400);
      chk("contend_first_latency", (start_cnt > base_s) && (cyc > t0 + 2), 1);
      chk("contend_sb", exp_q.size(), 0);
      settle();
    end

    // Fairness after skip: last served 1, requesters 0 and 2 pending
    base_d = done_cnt;
    lane_push(1, 8'hC1, 1'b1); exp_push(1, 8'hC1); drive_lanes();
    wait_for("skip_prep_done", 0, base_d + 1, 200);
    settle();
    lane_push(0, 8'hC0, 1'b1); lane_push(2, 8'hC2, 1'b1);
    exp_push(2, 8'hC2); exp_push(0, 8'hC0);
    drive_lanes();
    wait_for("skip_done", 0, base_d + 3, 300);
    chk("skip_sb", exp_q.size(), 0);
    settle();

    // Stall: requester 1 withholds its second byte
    base_d = done_cnt; base_a = abort_cnt; base_s = start_cnt;
    lane_push(1, 8'h41, 1'b0); lane_push(2, 8'hD2, 1'b1);
    exp_push(1, 8'h41); exp_push(2, 8'hD2);
    drive_lanes();
    wait_for("stall_first_start", 2, base_s + 1, 100);
    s41 = last_start_cyc;
    wait_for("stall_abort", 1, base_a + 1, 300);
    chk("abort_time", last_abort_cyc - s41, BUSY_CYC + 2 + TIMEOUT);
    wait_for("stall_next_start", 2, base_s + 2, 200);
    chk("after_abort_gap", (last_start_cyc - last_abort_cyc) >= IDLE_GAP + 3, 1);
    wait_for("stall_next_done", 0, base_d + 1, 200);
    chk("stall_done_only_req2", done_cnt - base_d, 1);
    chk("stall_abort_once", abort_cnt - base_a, 1);
    chk("stall_sb", exp_q.size(), 0);
    settle();

    // Back-to-back single-byte frames from requester 0
    base_d = done_cnt;
    lane_push(0, 8'hE0, 1'b1); lane_push(0, 8'hE1, 1'b1);
    exp_push(0, 8'hE0); exp_push(0, 8'hE1);
    drive_lanes();
    wait_for("b2b_first_done", 0, base_d + 1, 200);
    dc1 = last_done_cyc;
    wait_for("b2b_second_done", 0, base_d + 2, 200);
    chk("b2b_spacing", (last_start_cyc - dc1) >= IDLE_GAP + 3, 1);
    chk("b2b_sb", exp_q.size(), 0);
    settle();

    // Reset during DRAIN, then a clean frame
    base_s = start_cnt;
    lane_push(0, 8'hF0, 1'b0); lane_push(0, 8'hF1, 1'b1);
    exp_push(0, 8'hF0); exp_push(0, 8'hF1);
    drive_lanes();
    wait_for("mid_rst_start", 2, base_s + 1, 100);
    repeat (3) tick();
    chk("pre_rst_busy", tx_busy, 1);
    chk("pre_rst_grant", grant, 3'b001);
    base_d = done_cnt; base_a = abort_cnt;
    rst = 1'b1;
    #1;
    chk("mid_rst_outputs", {grant, req_ready, tx_start, tx_data, frame_done, frame_abort}, 0);
    flush();
    repeat (2) tick();
    rst = 1'b0;
    tick();
    chk("mid_rst_no_pulse", (done_cnt - base_d) + (abort_cnt - base_a), 0);
    lane_push(0, 8'hF0, 1'b0); lane_push(0, 8'hF1, 1'b1);
    exp_push(0, 8'hF0); exp_push(0, 8'hF1);
    drive_lanes();
    wait_for("post_rst_done", 0, base_d + 1, 200);
    chk("post_rst_sb", exp_q.size(), 0);
    settle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
